// File: rtl/dmem_arbiter_if.sv
// Data-memory master port bundle: req/we/addr/wdata toward the arbiter,
// gnt/rvalid/rdata back to the master. Ports: master and slave modports.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-RAM port between two masters.
// Ports: clk, rst, m0/m1 slave bundles, ram_en/we/addr/wdata out, ram_rdata in.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // RD_LAT is legal in 1..4, so the wait counter fits in two bits.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t            state;
  state_t            state_d;
  logic              sel;
  logic              sel_d;
  logic              pick;
  logic              lat_we;
  logic              last_grant;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              in_issue;
  logic              in_resp;
  logic              cap;

  assign in_issue = (state == ISSUE);
  assign in_resp  = (state == RESP);
  assign cap      = (state == WAIT) && (cnt == 2'd0);

  // On a tie the master that did not win last time is chosen.
  always_comb begin
    state_d = state;
    pick    = 1'b0;
    sel_d   = sel;
    unique case (state)
      IDLE: begin
        if (m0.req || m1.req) begin
          state_d = ISSUE;
          pick    = 1'b1;
          if (m0.req && m1.req) begin
            sel_d = ~last_grant;
          end else begin
            sel_d = m1.req;
          end
        end
      end
      ISSUE: begin
        state_d = lat_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      lat_we     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_grant <= 1'b1;
      cnt        <= 2'd0;
    end else begin
      state <= state_d;
      if (pick) begin
        sel     <= sel_d;
        lat_we  <= sel_d ? m1.we : m0.we;
        addr_q  <= sel_d ? m1.addr : m0.addr;
        wdata_q <= sel_d ? m1.wdata : m0.wdata;
      end
      if (in_issue) begin
        last_grant <= sel;
        cnt        <= CNT_INIT;
      end else if (state == WAIT && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // Each master keeps its last read result until its next read lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (cap) begin
      if (sel) begin
        rdata1_q <= ram_rdata;
      end else begin
        rdata0_q <= ram_rdata;
      end
    end
  end

  assign ram_en    = in_issue;
  assign ram_we    = in_issue && lat_we;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign m0.gnt    = in_issue && !sel;
  assign m1.gnt    = in_issue && sel;
  assign m0.rvalid = in_resp && !sel;
  assign m1.rvalid = in_resp && sel;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 3), RAM models,
// rdata scoreboard per master, one task per scenario.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  logic          a_en, a_we, b_en, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, a_rdata, b_wdata, b_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_a (
    .clk       (clk),
    .rst       (rst),
    .m0        (a0),
    .m1        (a1),
    .ram_en    (a_en),
    .ram_we    (a_we),
    .ram_addr  (a_addr),
    .ram_wdata (a_wdata),
    .ram_rdata (a_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_b (
    .clk       (clk),
    .rst       (rst),
    .m0        (b0),
    .m1        (b1),
    .ram_en    (b_en),
    .ram_we    (b_we),
    .ram_addr  (b_addr),
    .ram_wdata (b_wdata),
    .ram_rdata (b_rdata)
  );

  // RAM models: read data is valid only RD_LAT edges after the enable cycle.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [3];

  always @(posedge clk) begin
    if (a_en && a_we) mem_a[a_addr[7:0]] <= a_wdata;
    pipe_a <= (a_en && !a_we) ? mem_a[a_addr[7:0]] : 32'hBAD0_0001;
  end
  assign a_rdata = pipe_a;

  always @(posedge clk) begin
    if (b_en && b_we) mem_b[b_addr[7:0]] <= b_wdata;
    pipe_b[0] <= (b_en && !b_we) ? mem_b[b_addr[7:0]] : 32'hBAD0_0003;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_rdata = pipe_b[2];

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_a0 [$];
  logic [DW-1:0] exp_a1 [$];
  logic [DW-1:0] exp_b0 [$];
  logic [DW-1:0] exp_b1 [$];
  int gq [$];

  // Scoreboard: every rvalid pops the oldest expected rdata of that master.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (a0.rvalid) begin
      n_vec++;
      if (exp_a0.size() == 0) begin
        n_err++;
        $display("FAIL a_m0_rvalid unexpected, rdata=%h", a0.rdata);
      end else begin
        e = exp_a0.pop_front();
        if (a0.rdata !== e) begin
          n_err++;
          $display("FAIL a_m0_rdata got %h want %h", a0.rdata, e);
        end
      end
    end
    if (a1.rvalid) begin
      n_vec++;
      if (exp_a1.size() == 0) begin
        n_err++;
        $display("FAIL a_m1_rvalid unexpected, rdata=%h", a1.rdata);
      end else begin
        e = exp_a1.pop_front();
        if (a1.rdata !== e) begin
          n_err++;
          $display("FAIL a_m1_rdata got %h want %h", a1.rdata, e);
        end
      end
    end
    if (b0.rvalid) begin
      n_vec++;
      if (exp_b0.size() == 0) begin
        n_err++;
        $display("FAIL b_m0_rvalid unexpected, rdata=%h", b0.rdata);
      end else begin
        e = exp_b0.pop_front();
        if (b0.rdata !== e) begin
          n_err++;
          $display("FAIL b_m0_rdata got %h want %h", b0.rdata, e);
        end
      end
    end
    if (b1.rvalid) begin
      n_vec++;
      if (exp_b1.size() == 0) begin
        n_err++;
        $display("FAIL b_m1_rvalid unexpected, rdata=%h", b1.rdata);
      end else begin
        e = exp_b1.pop_front();
        if (b1.rdata !== e) begin
          n_err++;
          $display("FAIL b_m1_rdata got %h want %h", b1.rdata, e);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({a0.gnt, a0.rvalid, a0.rdata, a1.gnt, a1.rvalid, a1.rdata,
         a_en, a_we, a_addr, a_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_a outputs not zero: gnt=%b%b rv=%b%b en=%b",
               a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a_en);
    end
    n_vec++;
    if ({b0.gnt, b0.rvalid, b0.rdata, b1.gnt, b1.rvalid, b1.rdata,
         b_en, b_we, b_addr, b_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_b outputs not zero: gnt=%b%b rv=%b%b en=%b",
               b0.gnt, b1.gnt, b0.rvalid, b1.rvalid, b_en);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    a0.we = 1'b1;
    a0.addr = 32'h10;
    a0.wdata = 32'hDEAD_BEEF;
    a0.req = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({a0.gnt, a_en, a_we, a1.gnt, a1.rvalid} !== 5'b11100 ||
        a_addr !== 32'h10 || a_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL write_issue got gnt=%b en=%b we=%b m1gnt=%b addr=%h wd=%h want 1 1 1 0 10 deadbeef",
               a0.gnt, a_en, a_we, a1.gnt, a_addr, a_wdata);
    end
    a0.req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a0.gnt, a_en, a_we, a1.gnt, a1.rvalid, a0.rvalid} !== 6'b0) begin
      n_err++;
      $display("FAIL write_idle got gnt=%b en=%b we=%b want 0 0 0",
               a0.gnt, a_en, a_we);
    end
  endtask

  task automatic test_read;
    a1.we = 1'b0;
    a1.addr = 32'h20;
    a1.req = 1'b1;
    exp_a1.push_back(32'h1234_5678);
    @(negedge clk);
    n_vec++;
    if ({a1.gnt, a0.gnt, a_en, a_we} !== 4'b1010 || a_addr !== 32'h20) begin
      n_err++;
      $display("FAIL read_issue got m1gnt=%b m0gnt=%b en=%b we=%b addr=%h want 1 0 1 0 20",
               a1.gnt, a0.gnt, a_en, a_we, a_addr);
    end
    a1.req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a1.rvalid, a0.rvalid, a_en} !== 3'b000) begin
      n_err++;
      $display("FAIL read_wait got m1rv=%b m0rv=%b en=%b want 0 0 0",
               a1.rvalid, a0.rvalid, a_en);
    end
    @(negedge clk);
    n_vec++;
    if ({a1.rvalid, a0.rvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL read_resp got m1rv=%b m0rv=%b want 1 0", a1.rvalid, a0.rvalid);
    end
    @(negedge clk);
    n_vec++;
    if (a1.rvalid !== 1'b0 || a1.rdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL read_hold got rv=%b rdata=%h want 0 12345678", a1.rvalid, a1.rdata);
    end
  endtask

  task automatic test_tie;
    int seen;
    int who;
    int e;
    rst = 1'b1;
    @(negedge clk);
    a0.we = 1'b1;
    a0.addr = 32'h40;
    a0.wdata = 32'h1111_0000;
    a1.we = 1'b1;
    a1.addr = 32'h44;
    a1.wdata = 32'h2222_0000;
    a0.req = 1'b1;
    a1.req = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) gq.push_back(i % 2);
    seen = 0;
    for (int c = 0; c < 40 && seen < 8; c++) begin
      @(negedge clk);
      if (a0.gnt || a1.gnt) begin
        who = a1.gnt ? 1 : 0;
        e = gq.pop_front();
        n_vec++;
        if ((a0.gnt && a1.gnt) || who != e ||
            a_addr !== (who == 1 ? 32'h44 : 32'h40)) begin
          n_err++;
          $display("FAIL tie_order grant %0d got m%0d addr=%h want m%0d",
                   seen, who, a_addr, e);
        end
        seen++;
      end
    end
    a0.req = 1'b0;
    a1.req = 1'b0;
    n_vec++;
    if (seen != 8) begin
      n_err++;
      $display("FAIL tie_timeout got %0d grants want 8", seen);
    end
    gq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fair;
    int seen;
    int who;
    int e;
    a0.we = 1'b1;
    a0.addr = 32'h50;
    a0.wdata = 32'h5555_0000;
    a1.we = 1'b1;
    a1.addr = 32'h54;
    a1.wdata = 32'h6666_0000;
    a0.req = 1'b1;
    gq = {0, 1, 0, 0};
    seen = 0;
    for (int c = 0; c < 30 && seen < 4; c++) begin
      @(negedge clk);
      if (a0.gnt || a1.gnt) begin
        who = a1.gnt ? 1 : 0;
        e = gq.pop_front();
        n_vec++;
        if ((a0.gnt && a1.gnt) || who != e) begin
          n_err++;
          $display("FAIL fair_order grant %0d got m%0d want m%0d", seen, who, e);
        end
        if (seen == 0) a1.req = 1'b1;
        if (who == 1) a1.req = 1'b0;
        seen++;
      end
    end
    a0.req = 1'b0;
    a1.req = 1'b0;
    n_vec++;
    if (seen != 4) begin
      n_err++;
      $display("FAIL fair_timeout got %0d grants want 4", seen);
    end
    gq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lat3;
    logic [4:0] got;
    logic [4:0] want;
    b0.we = 1'b0;
    b0.addr = 32'h30;
    b1.we = 1'b1;
    b1.addr = 32'h34;
    b1.wdata = 32'h7777_0000;
    b0.req = 1'b1;
    b1.req = 1'b1;
    exp_b0.push_back(32'hB000_0030);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      got = {b0.gnt, b0.rvalid, b1.gnt, b1.rvalid, b_en};
      want = {c == 1, c == 5, c == 7, 1'b0, c == 1 || c == 7};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL lat3_cycle%0d got gnt0/rv0/gnt1/rv1/en=%b want %b", c, got, want);
      end
      if (b0.gnt) b0.req = 1'b0;
      if (b1.gnt) b1.req = 1'b0;
    end
    b0.req = 1'b0;
    b1.req = 1'b0;
  endtask

  task automatic test_abort;
    a1.we = 1'b0;
    a1.addr = 32'h24;
    a1.req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (a1.gnt !== 1'b1) begin
      n_err++;
      $display("FAIL abort_gnt got %b want 1", a1.gnt);
    end
    a1.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({a0.gnt, a0.rvalid, a0.rdata, a1.gnt, a1.rvalid, a1.rdata,
         a_en, a_we, a_addr, a_wdata} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs not zero: rv1=%b rdata1=%h addr=%h",
               a1.rvalid, a1.rdata, a_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if ({a1.rvalid, a1.gnt, a_en} !== 3'b000) begin
        n_err++;
        $display("FAIL abort_quiet cycle%0d got rv=%b gnt=%b en=%b want 0 0 0",
                 c, a1.rvalid, a1.gnt, a_en);
      end
    end
    a0.we = 1'b1;
    a0.addr = 32'h60;
    a0.wdata = 32'h8888_0000;
    a1.we = 1'b1;
    a1.addr = 32'h64;
    a1.wdata = 32'h9999_0000;
    a0.req = 1'b1;
    a1.req = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({a0.gnt, a1.gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_tie_first got gnt0/gnt1=%b%b want 10", a0.gnt, a1.gnt);
    end
    a0.req = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a0.gnt, a1.gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL abort_tie_second got gnt0/gnt1=%b%b want 01", a0.gnt, a1.gnt);
    end
    a1.req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int c;
    a0.we = 1'b0;
    a0.addr = 32'h10;
    a1.we = 1'b0;
    a1.addr = 32'h44;
    a0.req = 1'b1;
    a1.req = 1'b1;
    exp_a0.push_back(32'hDEAD_BEEF);
    exp_a1.push_back(32'h2222_0000);
    c = 0;
    while (c < 30 && (exp_a0.size() != 0 || exp_a1.size() != 0)) begin
      @(negedge clk);
      if (a0.gnt) a0.req = 1'b0;
      if (a1.gnt) a1.req = 1'b0;
      c++;
    end
    a0.req = 1'b0;
    a1.req = 1'b0;
    n_vec++;
    if (exp_a0.size() != 0 || exp_a1.size() != 0) begin
      n_err++;
      $display("FAIL b2b_timeout pending m0=%0d m1=%0d want 0 0",
               exp_a0.size(), exp_a1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hA000_0000 | 32'(i);
      mem_b[i] = 32'hB000_0000 | 32'(i);
    end
    mem_a[8'h20] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) pipe_b[i] = '0;
    pipe_a = '0;
    a0.req = 1'b0; a0.we = 1'b0; a0.addr = '0; a0.wdata = '0;
    a1.req = 1'b0; a1.we = 1'b0; a1.addr = '0; a1.wdata = '0;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
    b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_fair();
    test_lat3();
    test_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_a0.size() + exp_a1.size() + exp_b0.size() + exp_b1.size() != 0) begin
      n_err++;
      $display("FAIL drain outstanding reads got %0d want 0",
               exp_a0.size() + exp_a1.size() + exp_b0.size() + exp_b1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data-RAM port (en/we/addr/wdata/rdata) between the CPU load/store unit (m0) and a second bus master (m1, e.g. UART boot loader or debug port). It uses round-robin arbitration with a registered req/gnt handshake. It is read-latency aware and returns read data to the winning master with a one-cycle rvalid pulse. It sits between the CPU data interface and the RAM in the top level.

Parameters:
ADDR_W, 32, address width of masters and RAM
DATA_W, 32, data width
RD_LAT, 1, RAM read latency in clock edges after the enable cycle (legal 1..4)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
m0_req  in  1  CPU request, held with cmd fields stable until m0_gnt
m0_we  in  1  1=write, 0=read
m0_addr  in  ADDR_W  CPU address
m0_wdata  in  DATA_W  CPU write data
m0_gnt  out  1  one-cycle grant pulse, coincides with the RAM access cycle
m0_rvalid  out  1  one-cycle pulse, m0_rdata valid
m0_rdata  out  DATA_W  registered read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0 for master 1
ram_en  out  1  RAM enable, high only in ISSUE
ram_we  out  1  RAM write enable, high only in ISSUE for writes
ram_addr  out  ADDR_W  latched address of current transaction
ram_wdata  out  DATA_W  latched write data
ram_rdata  in  DATA_W  RAM read data, valid RD_LAT edges after the ISSUE cycle

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; rdata regs 0; last_grant=1, so m0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample reqs at the clock edge.
  - Neither asserted: stay in IDLE.
  - One asserted: select it.
  - Both asserted: select the master != last_grant.
  - On selection, latch sel, we, addr, wdata; go to ISSUE.
- ISSUE (exactly 1 cycle): ram_en=1; ram_we=latched we; gnt_sel=1; last_grant<=sel.
  - Write: go to IDLE.
  - Read: load counter with RD_LAT-1, go to WAIT.
- WAIT: decrement the counter each cycle. At counter 0, capture ram_rdata into rdata_sel and go to RESP. WAIT lasts exactly RD_LAT cycles.
- RESP (1 cycle): rvalid_sel=1; rdata_sel holds the captured value until that master's next read completes. Go to IDLE.
- Latency from the req-sampling edge:
  - Write: gnt/ram_en in the next cycle; throughput 1 access per 2 cycles.
  - Read: rvalid RD_LAT+1 cycles after the ISSUE cycle.
- Reqs are not sampled in ISSUE/WAIT/RESP; a master waiting stays pending.
- Once a req is latched, the transaction completes even if that req drops before gnt.
- The non-selected master's gnt and rvalid stay 0 throughout.
- ram_addr/ram_wdata hold their last latched values outside ISSUE; ram_en/ram_we are 0 outside ISSUE.
- Reset asserted in any state aborts the transaction: no gnt/rvalid is ever produced for it, and the RAM sees no further enable.

Test Plan:
1. m0 write alone, addr 0x10, data 0xDEADBEEF: m0_gnt=1 one cycle after sampling, with ram_en=ram_we=1, ram_addr=0x10, ram_wdata=0xDEADBEEF. Next cycle IDLE with ram_en=0. m1 outputs stay 0.
2. m1 read addr 0x20, RD_LAT=1, RAM model returns 0x12345678: m1_gnt in ISSUE, m1_rvalid=1 two cycles later with m1_rdata=0x12345678. m0_rvalid never asserts.
3. m0_req and m1_req both asserted at the first edge after reset release: order is m0 then m1. Both held continuously: grants alternate 0,1,0,1 across 8 transactions.
4. m0 req held continuously, m1 asserts once: m1 is granted on the next arbitration, then m0 resumes.
5. m0 read with RD_LAT=3: m0_rvalid exactly 4 cycles after the ISSUE cycle. A simultaneous m1 write is granted only after RESP.
6. rst pulsed during WAIT of an m1 read: all outputs 0 immediately; no m1_rvalid after release. A subsequent tie grants m0 first.
